// File: rtl/crc_pkg.sv
// Types and constants shared by the CRC-32 feeder and the single-word CRC engine.
package crc_pkg;

    typedef logic [31:0] crc_word_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } feeder_state_e;

    localparam crc_word_t CRC32_POLY = 32'h04C1_1DB7;

    // One MSB-first bit step of the CRC-32 LFSR, used by the engine side.
    function automatic crc_word_t crc32_step(crc_word_t crc, logic din);
        return (crc << 1) ^ (((crc[31] ^ din) == 1'b1) ? CRC32_POLY : '0);
    endfunction

endpackage

// File: rtl/crc_word_feeder_if.sv
// Valid/ready word stream carrying 32-bit words into the CRC feeder.
interface crc_word_feeder_if;
    import crc_pkg::*;

    logic      s_valid;
    crc_word_t s_data;
    logic      s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and a one-cycle flush that also discards a push.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FullCnt = DEPTH[AW:0];
    localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PtrOne;
            if (do_pop)  rptr_d = rptr_q + PtrOne;
            if (do_push && !do_pop)      count_d = count_q + CntOne;
            else if (do_pop && !do_push) count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/crc_word_feeder.sv
// Buffers stream words and hands them one at a time to the CRC engine, waiting for a rising
// done edge per word, counting completions and flagging words abandoned on timeout.
module crc_word_feeder
    import crc_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    crc_word_feeder_if.slave       s_if,
    input  logic                   flush,
    output crc_word_t              crc_data,
    output logic                   crc_start,
    input  logic                   crc_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]       words_done,
    output logic                   err_timeout
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0]    TimerLast = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]    TimerOne  = TW'(1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    feeder_state_e    state_q, state_d;
    crc_word_t        crc_data_q, crc_data_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] words_done_q, words_done_d;
    logic             err_q, err_d;
    logic             done_q;

    logic      fifo_pop, fifo_full, fifo_empty;
    crc_word_t fifo_rdata;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s_if.s_valid),
        .pop_i   (fifo_pop),
        .flush_i (flush),
        .wdata_i (s_if.s_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign s_if.s_ready = !fifo_full;
    assign crc_data     = crc_data_q;
    assign busy         = (state_q != IDLE);
    assign words_done   = words_done_q;
    assign err_timeout  = err_q;

    always_comb begin
        state_d      = state_q;
        crc_data_d   = crc_data_q;
        timer_d      = timer_q;
        words_done_d = words_done_q;
        err_d        = err_q;
        fifo_pop     = 1'b0;
        crc_start    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    crc_data_d = fifo_rdata;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                crc_start = 1'b1;
                timer_d   = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // A done level left over from the previous word must not complete this one.
                if (crc_done && !done_q) begin
                    words_done_d = words_done_q + CntOne;
                    state_d      = IDLE;
                end else if (timer_q == TimerLast) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            crc_data_q   <= '0;
            timer_q      <= '0;
            words_done_q <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_data_q   <= crc_data_d;
            timer_q      <= timer_d;
            words_done_q <= words_done_d;
            err_q        <= err_d;
            done_q       <= crc_done;
        end
    end

endmodule
